conv_ctrl_gen: RTL and testbench

Parametrised successor of the 6-kernel convolution controller. It sequences kernel loads, input-row loads, per-pixel MAC passes and result emission for a conv layer. Group size, kernel word count, row word count, feature-map size and channel count are all parameters. It handles a partial last kernel group, per-word handshaking on the load stream, and back-pressure on results. It sits between the external con_valid/con_ready stream and the KDS/IDSS/MAC datapath.

---
 rtl/conv_ctrl_pkg.sv | 45 ++++
 rtl/wrap_counter.sv | 34 +++
 rtl/conv_ctrl_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_conv_ctrl_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and elaboration helpers for the parametrised convolution
// controller.
//
// Contents:
//   fsm_state  - controller state encoding
//   idx_width  - index width for a range of n values (at least 1 bit)
//   nb_groups  - number of kernel groups needed to cover all output channels
//   nk_of      - kernels present in group g (the last group may be partial)
//   NB_GROUPS, LAST_NK, *_W - derived values for the default configuration
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_K  = 3'd1,
        ST_LOAD_I  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_EMIT    = 3'd4
    } fsm_state;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int nb_groups(input int oc, input int kg);
        return (oc + kg - 1) / kg;
    endfunction

    function automatic int nk_of(input int g, input int oc, input int kg);
        int rem;
        rem = oc - g * kg;
        return (rem < kg) ? rem : kg;
    endfunction

    localparam int DEF_OC        = 32;
    localparam int DEF_K_GROUP   = 6;
    localparam int DEF_K_WORDS   = 12;
    localparam int DEF_I_WORDS   = 4;

    localparam int NB_GROUPS     = nb_groups(DEF_OC, DEF_K_GROUP);
    localparam int LAST_NK       = nk_of(NB_GROUPS - 1, DEF_OC, DEF_K_GROUP);
    localparam int KERNEL_IDX_W  = idx_width(DEF_K_GROUP);
    localparam int K_WORD_IDX_W  = idx_width(DEF_K_WORDS);
    localparam int I_WORD_IDX_W  = idx_width(DEF_I_WORDS);

endpackage

// File: rtl/wrap_counter.sv
// Index counter that counts 0..max and wraps back to 0.
//
// Ports:
//   clk, arst_n_in - clock, asynchronous active-low reset
//   clr            - synchronous clear to 0 (wins over inc)
//   inc            - advance by one, wrapping to 0 after max
//   max            - terminal value, may change at run time
//   cnt            - current index
//   last           - cnt equals max (next inc wraps)
module wrap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    assign last = (cnt == max);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_ctrl_gen.sv
// Convolution layer controller: sequences kernel-group loads, input-row
// loads, per-pixel MAC passes and result emission between the con_* load
// stream and the KDS/IDSS/MAC datapath.
//
// Ports:
//   clk, arst_n_in        - clock, asynchronous active-low reset
//   start                 - begin a layer (only looked at in IDLE)
//   running, done         - busy flag, one-cycle completion pulse
//   con_valid, con_ready  - load/compute stream handshake
//   ld_k_we/kernel/word   - KDS write strobe and address
//   ld_i_we/word          - IDSS write strobe and word index
//   i_shift               - shift IDSS by one row
//   mac_en, mac_clear     - MAC accumulate / clear on first word of a pass
//   out_valid, out_ready  - result handshake
//   out_x, out_y, out_ch  - coordinates of the presented result
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for start, all strobes low
// ST_LOAD_K  | streaming nk*K_WORDS kernel words into the KDS
// ST_LOAD_I  | streaming KERNEL_SIZE rows of I_WORDS words into IDSS
// ST_COMPUTE | one MAC pass of I_WORDS words for pixel (x, y)
// ST_EMIT    | presenting nk results for (x, y), one per accept
module conv_ctrl_gen
    import conv_ctrl_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int KERNEL_SIZE        = 3,
    parameter int K_GROUP            = 6,
    parameter int K_WORDS            = 12,
    parameter int I_WORDS            = 4
) (
    input  logic                           clk,
    input  logic                           arst_n_in,
    input  logic                           start,
    output logic                           running,
    output logic                           done,
    input  logic                           con_valid,
    output logic                           con_ready,
    output logic                           ld_k_we,
    output logic [idx_width(K_GROUP)-1:0]  ld_k_kernel,
    output logic [idx_width(K_WORDS)-1:0]  ld_k_word,
    output logic                           ld_i_we,
    output logic [idx_width(I_WORDS)-1:0]  ld_i_word,
    output logic                           i_shift,
    output logic                           mac_en,
    output logic                           mac_clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_x,
    output logic [31:0]                    out_y,
    output logic [31:0]                    out_ch
);

    localparam int KK_W  = idx_width(K_GROUP);
    localparam int KW_W  = idx_width(K_WORDS);
    localparam int IW_W  = idx_width(I_WORDS);
    localparam int ROW_W = idx_width(KERNEL_SIZE);
    localparam int X_W   = idx_width(FEATURE_MAP_WIDTH);
    localparam int Y_W   = idx_width(FEATURE_MAP_HEIGHT);
    localparam int N_GRP = nb_groups(OUTPUT_NB_CHANNELS, K_GROUP);
    localparam int G_W   = idx_width(N_GRP);

    localparam logic [KW_W-1:0]  KW_MAX  = KW_W'(K_WORDS - 1);
    localparam logic [IW_W-1:0]  IW_MAX  = IW_W'(I_WORDS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [X_W-1:0]   X_MAX   = X_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [G_W-1:0]   G_MAX   = G_W'(N_GRP - 1);
    localparam logic [31:0]      CH_STEP = 32'(K_GROUP);

    fsm_state state_q, state_nx;

    logic [KW_W-1:0]  kw_cnt;
    logic [KK_W-1:0]  kern_cnt;
    logic [IW_W-1:0]  iw_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt;
    logic [G_W-1:0]   g_cnt;
    logic [KK_W-1:0]  j_cnt;
    logic kw_last, kern_last, iw_last, row_last, x_last, y_last, g_last, j_last;

    logic [KK_W-1:0] nk_m1;
    logic [31:0]     ch_base_q;
    logic            done_q;

    logic cnt_clr, k_xfer, i_xfer, c_xfer, emit_acc, pix_done, row_adv, group_adv;
    logic layer_done;
    logic unused_row;

    assign cnt_clr    = (state_q == ST_IDLE) && start;
    assign k_xfer     = (state_q == ST_LOAD_K) && con_valid;
    assign i_xfer     = (state_q == ST_LOAD_I) && con_valid;
    assign c_xfer     = (state_q == ST_COMPUTE) && con_valid;
    assign emit_acc   = (state_q == ST_EMIT) && out_ready;
    assign pix_done   = emit_acc && j_last;
    assign row_adv    = pix_done && x_last;
    assign group_adv  = row_adv && y_last;
    assign layer_done = group_adv && g_last;

    // The row index itself is never needed, only its terminal flag.
    assign unused_row = ^row_cnt;

    // Kernels in the current group; only the last group can be short.
    always_comb begin
        nk_m1 = KK_W'(nk_of(int'(g_cnt), OUTPUT_NB_CHANNELS, K_GROUP) - 1);
    end

    wrap_counter #(.WIDTH(KW_W)) u_kw_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(k_xfer),
        .max(KW_MAX), .cnt(kw_cnt), .last(kw_last)
    );

    wrap_counter #(.WIDTH(KK_W)) u_kern_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(k_xfer && kw_last),
        .max(nk_m1), .cnt(kern_cnt), .last(kern_last)
    );

    // Shared by row loads and compute passes: both walk I_WORDS words.
    wrap_counter #(.WIDTH(IW_W)) u_iw_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(i_xfer || c_xfer),
        .max(IW_MAX), .cnt(iw_cnt), .last(iw_last)
    );

    wrap_counter #(.WIDTH(ROW_W)) u_row_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(i_xfer && iw_last),
        .max(ROW_MAX), .cnt(row_cnt), .last(row_last)
    );

    // x, y and group wrap to 0 exactly when the next-outer index advances.
    wrap_counter #(.WIDTH(X_W)) u_x_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(pix_done),
        .max(X_MAX), .cnt(x_cnt), .last(x_last)
    );

    wrap_counter #(.WIDTH(Y_W)) u_y_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(row_adv),
        .max(Y_MAX), .cnt(y_cnt), .last(y_last)
    );

    wrap_counter #(.WIDTH(G_W)) u_g_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(group_adv),
        .max(G_MAX), .cnt(g_cnt), .last(g_last)
    );

    wrap_counter #(.WIDTH(KK_W)) u_j_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .clr(cnt_clr), .inc(emit_acc),
        .max(nk_m1), .cnt(j_cnt), .last(j_last)
    );

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q   <= ST_IDLE;
            ch_base_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            done_q  <= layer_done;
            if (cnt_clr) begin
                ch_base_q <= '0;
            end else if (group_adv) begin
                ch_base_q <= g_last ? '0 : ch_base_q + CH_STEP;
            end
        end
    end

    always_comb begin
        state_nx  = state_q;
        con_ready = 1'b0;
        ld_k_we   = 1'b0;
        ld_i_we   = 1'b0;
        i_shift   = 1'b0;
        mac_en    = 1'b0;
        mac_clear = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_LOAD_K;
                end
            end
            ST_LOAD_K: begin
                con_ready = 1'b1;
                ld_k_we   = con_valid;
                if (con_valid && kw_last && kern_last) begin
                    state_nx = ST_LOAD_I;
                end
            end
            ST_LOAD_I: begin
                con_ready = 1'b1;
                ld_i_we   = con_valid;
                i_shift   = con_valid && iw_last;
                if (con_valid && iw_last && row_last) begin
                    state_nx = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                con_ready = 1'b1;
                mac_en    = con_valid;
                mac_clear = con_valid && (iw_cnt == '0);
                i_shift   = con_valid && iw_last;
                if (con_valid && iw_last) begin
                    state_nx = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (pix_done) begin
                    if (!x_last) begin
                        state_nx = ST_COMPUTE;
                    end else if (!y_last) begin
                        state_nx = ST_LOAD_I;
                    end else if (!g_last) begin
                        state_nx = ST_LOAD_K;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign running     = (state_q != ST_IDLE);
    assign done        = done_q;
    assign ld_k_kernel = kern_cnt;
    assign ld_k_word   = kw_cnt;
    assign ld_i_word   = iw_cnt;
    assign out_x       = 32'(x_cnt);
    assign out_y       = 32'(y_cnt);
    assign out_ch      = ch_base_q + 32'(j_cnt);

endmodule

// File: tb/tb_conv_ctrl_gen.sv
// Bench for conv_ctrl_gen (W=H=2, OC=8, K_GROUP=6, K_WORDS=12, I_WORDS=4).
// The reference is an ordered list of expected stream words and results,
// built from nested loops over groups, rows, pixels and kernels.
module tb_conv_ctrl_gen;

    localparam int W   = 2;
    localparam int H   = 2;
    localparam int OC  = 8;
    localparam int KS  = 3;
    localparam int KG  = 6;
    localparam int KWD = 12;
    localparam int IWD = 4;
    localparam int NG  = (OC + KG - 1) / KG;
    localparam int KK_W = (KG  > 1) ? $clog2(KG)  : 1;
    localparam int KW_W = (KWD > 1) ? $clog2(KWD) : 1;
    localparam int IW_W = (IWD > 1) ? $clog2(IWD) : 1;

    localparam int EV_K = 0;
    localparam int EV_I = 1;
    localparam int EV_C = 2;
    localparam int EV_R = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        bit shift;
        bit clear;
        int g;
    } ev_t;

    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    logic start = 1'b0;
    logic con_valid = 1'b0;
    logic out_ready = 1'b0;
    logic running, done, con_ready, ld_k_we, ld_i_we, i_shift, mac_en, mac_clear, out_valid;
    logic [KK_W-1:0] ld_k_kernel;
    logic [KW_W-1:0] ld_k_word;
    logic [IW_W-1:0] ld_i_word;
    logic [31:0] out_x, out_y, out_ch;
    logic [8:0] obs_ctl;

    ev_t q[$];
    int  n_assert, n_fail;
    int  n_k[NG];
    int  n_i, n_mac, n_res, n_done, n_seen, k_hold, r_hold;
    bit  seen[W][H][OC];
    bit  done_next, full_rate, k_stall_done, r_stall_done;
    int  k_stall, r_stall;

    conv_ctrl_gen #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC),
        .KERNEL_SIZE(KS), .K_GROUP(KG), .K_WORDS(KWD), .I_WORDS(IWD)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .done(done),
        .con_valid(con_valid), .con_ready(con_ready),
        .ld_k_we(ld_k_we), .ld_k_kernel(ld_k_kernel), .ld_k_word(ld_k_word),
        .ld_i_we(ld_i_we), .ld_i_word(ld_i_word), .i_shift(i_shift),
        .mac_en(mac_en), .mac_clear(mac_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch)
    );

    initial forever #5 clk = ~clk;

    // {done, con_ready, out_valid, running, ld_k_we, ld_i_we, i_shift, mac_en, mac_clear}
    assign obs_ctl = {done, con_ready, out_valid, running, ld_k_we, ld_i_we, i_shift, mac_en, mac_clear};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_ev(input int kind, input int a, input int b, input int c,
                                    input bit sh, input bit cl, input int g);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.shift = sh; e.clear = cl; e.g = g;
        q.push_back(e);
    endfunction

    function automatic int nk_ref(input int g);
        return (OC - g * KG < KG) ? OC - g * KG : KG;
    endfunction

    function automatic void build_model();
        q.delete();
        for (int g = 0; g < NG; g++) begin
            for (int k = 0; k < nk_ref(g); k++)
                for (int w = 0; w < KWD; w++)
                    push_ev(EV_K, k, w, 0, 1'b0, 1'b0, g);
            for (int y = 0; y < H; y++) begin
                for (int r = 0; r < KS; r++)
                    for (int w = 0; w < IWD; w++)
                        push_ev(EV_I, w, r, 0, w == IWD - 1, 1'b0, g);
                for (int x = 0; x < W; x++) begin
                    for (int w = 0; w < IWD; w++)
                        push_ev(EV_C, w, 0, 0, w == IWD - 1, w == 0, g);
                    for (int j = 0; j < nk_ref(g); j++)
                        push_ev(EV_R, x, y, g * KG + j, 1'b0, 1'b0, g);
                end
            end
        end
    endfunction

    task automatic clear_stats();
        for (int g = 0; g < NG; g++) n_k[g] = 0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                for (int c = 0; c < OC; c++) seen[x][y][c] = 1'b0;
        n_i = 0; n_mac = 0; n_res = 0; n_done = 0; n_seen = 0; k_hold = 0; r_hold = 0;
        k_stall = 0; r_stall = 0; k_stall_done = 1'b0; r_stall_done = 1'b0; done_next = 1'b0;
    endtask

    task automatic step();
        ev_t e;
        bit have, k_spot, r_spot, exp_done;
        logic [8:0] exp_ctl;
        @(negedge clk);
        have = (q.size() != 0);
        k_spot = 1'b0;
        r_spot = 1'b0;
        if (have) begin
            e = q[0];
            k_spot = (e.kind == EV_K) && (e.g == 0) && (e.a == 0) && (e.b == 5);
            r_spot = (e.kind == EV_R) && (e.g == 0) && (e.a == 0) && (e.b == 0) && (e.c == 2);
            con_valid = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 4) == 0);
            if (k_spot) begin
                if (!k_stall_done) begin k_stall = 3; k_stall_done = 1'b1; end
                if (k_stall > 0) begin con_valid = 1'b0; k_stall--; end
                else con_valid = 1'b1;
            end
            if (r_spot) begin
                if (!r_stall_done) begin r_stall = 5; r_stall_done = 1'b1; end
                if (r_stall > 0) begin out_ready = 1'b0; r_stall--; end
                else out_ready = 1'b1;
            end
        end else begin
            con_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            start     = 1'b0;
        end
        #1;
        exp_done  = done_next;
        done_next = 1'b0;
        exp_ctl   = '0;
        exp_ctl[8] = exp_done;
        if (have) begin
            exp_ctl[5] = 1'b1;
            case (e.kind)
                EV_K: begin
                    exp_ctl[7] = 1'b1;
                    exp_ctl[4] = con_valid;
                    chk("k_kernel", ld_k_kernel, e.a);
                    chk("k_word", ld_k_word, e.b);
                    if (k_spot && !ld_k_we && ld_k_word == 5) k_hold++;
                end
                EV_I: begin
                    exp_ctl[7] = 1'b1;
                    exp_ctl[3] = con_valid;
                    exp_ctl[2] = con_valid && e.shift;
                    chk("i_word", ld_i_word, e.a);
                end
                EV_C: begin
                    exp_ctl[7] = 1'b1;
                    exp_ctl[2] = con_valid && e.shift;
                    exp_ctl[1] = con_valid;
                    exp_ctl[0] = con_valid && e.clear;
                end
                default: begin
                    exp_ctl[6] = 1'b1;
                    chk("out_x", out_x, e.a);
                    chk("out_y", out_y, e.b);
                    chk("out_ch", out_ch, e.c);
                    if (r_spot && !out_ready && out_valid && out_ch == 2) r_hold++;
                end
            endcase
        end
        chk("ctl", obs_ctl, exp_ctl);
        if (have && e.kind == EV_K && ld_k_we) n_k[e.g]++;
        n_i   += int'(ld_i_we);
        n_mac += int'(mac_en);
        n_done += int'(done);
        if (out_valid && out_ready) begin
            n_res++;
            if (out_x < W && out_y < H && out_ch < OC) begin
                chk("dup_tuple", seen[out_x][out_y][out_ch], 0);
                if (!seen[out_x][out_y][out_ch]) n_seen++;
                seen[out_x][out_y][out_ch] = 1'b1;
            end
        end
        if (have) begin
            if ((e.kind == EV_R) ? out_ready : con_valid) begin
                if (q.size() == 1) done_next = 1'b1;
                void'(q.pop_front());
            end
        end
    endtask

    task automatic run_layer(input bit fr);
        int cyc;
        full_rate = fr;
        clear_stats();
        build_model();
        @(negedge clk);
        start = 1'b1;
        con_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_start_running", running, 0);
        cyc = 0;
        while (q.size() != 0 && cyc < 4000) begin
            step();
            cyc++;
        end
        chk("timeout_events_left", q.size(), 0);
        step();
        chk("running_after_done", running, 0);
        step();
        for (int g = 0; g < NG; g++) chk("k_xfers_per_group", n_k[g], nk_ref(g) * KWD);
        chk("i_xfers", n_i, NG * H * KS * IWD);
        chk("mac_words", n_mac, NG * H * W * IWD);
        chk("results", n_res, OC * W * H);
        chk("distinct_tuples", n_seen, OC * W * H);
        chk("done_pulses", n_done, 1);
        chk("k_stall_hold", k_hold, 3);
        chk("r_stall_hold", r_hold, 5);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clear_stats();
        arst_n_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctl", obs_ctl, 0);
        chk("rst_k_kernel", ld_k_kernel, 0);
        chk("rst_k_word", ld_k_word, 0);
        chk("rst_i_word", ld_i_word, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_ch", out_ch, 0);
        @(negedge clk);
        arst_n_in = 1'b1;

        // Partial kernel load, then reset in the middle of LOAD_K.
        full_rate = 1'b1;
        build_model();
        @(negedge clk);
        start = 1'b1;
        con_valid = 1'b0;
        #1;
        repeat (20) step();
        @(negedge clk);
        arst_n_in = 1'b0;
        start = 1'b0;
        con_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_ctl", obs_ctl, 0);
        chk("midrst_k_kernel", ld_k_kernel, 0);
        chk("midrst_k_word", ld_k_word, 0);
        @(posedge clk);
        #1;
        chk("midrst_ctl_edge", obs_ctl, 0);
        @(negedge clk);
        arst_n_in = 1'b1;
        con_valid = 1'b0;
        out_ready = 1'b0;

        run_layer(1'b1);
        run_layer(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
